// File: rtl/quiz_round_controller.sv
`default_nettype none
// ============================================================================
// quiz_round_controller : three-group buzzer arbiter, answer timer and scorer
// Revision 1.0 - initial release
// ============================================================================
module quiz_round_controller #(
  parameter int WINDOW  = 50,
  parameter int ANS_CYC = 30,
  parameter int SCORE_W = 4
) (
  input  logic               clk,
  input  logic               X5,
  input  logic               X0,
  input  logic               X1,
  input  logic               X2,
  input  logic               X3,
  input  logic               X4,
  input  logic               start,
  input  logic               judge_ok,
  input  logic               judge_bad,
  output logic               Y0,
  output logic               Y1,
  output logic               Y2,
  output logic               armed,
  output logic [2:0]         lock,
  output logic [SCORE_W-1:0] score0,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               round_done,
  output logic               timeout
);

  localparam int c_CNT_MAX = (WINDOW > ANS_CYC) ? WINDOW : ANS_CYC;
  localparam int c_CNT_W   = (c_CNT_MAX > 2) ? $clog2(c_CNT_MAX) : 1;
  localparam logic [c_CNT_W-1:0] c_WIN_LOAD  = c_CNT_W'(WINDOW - 1);
  localparam logic [c_CNT_W-1:0] c_ANS_LOAD  = c_CNT_W'(ANS_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
  localparam logic [SCORE_W-1:0] c_SCORE_MAX = '1;
  localparam logic [SCORE_W-1:0] c_SCORE_ONE = SCORE_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_ANSWER = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [c_CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]           lock_q, lock_d;
  logic [1:0]           rr_ptr_q, rr_ptr_d;
  logic [1:0]           win_q, win_d;
  logic [SCORE_W-1:0]   score_q [3];
  logic [SCORE_W-1:0]   score_d [3];
  logic [2:0]           lamp_q, lamp_d;
  logic                 armed_q, armed_d;
  logic                 round_done_q, round_done_d;
  logic                 timeout_q, timeout_d;

  logic [2:0]           w_req;
  logic [2:0]           w_elig;
  logic [1:0]           w_pick0, w_pick1, w_pick2;
  logic                 w_grant_vld;
  logic [1:0]           w_grant_idx;
  logic [2:0]           w_win_mask;
  logic [2:0]           w_lock_fail;

  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  assign w_req       = {X3 & X4, X2, X0 | X1};
  assign w_elig      = w_req & ~lock_q;
  assign w_win_mask  = 3'b001 << win_q;
  assign w_lock_fail = lock_q | w_win_mask;

  // Round-robin search order starts at rr_ptr and wraps modulo 3.
  assign w_pick0 = rr_ptr_q;
  assign w_pick1 = next_idx(w_pick0);
  assign w_pick2 = next_idx(w_pick1);

  always_comb begin
    w_grant_vld = 1'b1;
    w_grant_idx = w_pick0;
    if (w_elig[w_pick0]) begin
      w_grant_idx = w_pick0;
    end else if (w_elig[w_pick1]) begin
      w_grant_idx = w_pick1;
    end else if (w_elig[w_pick2]) begin
      w_grant_idx = w_pick2;
    end else begin
      w_grant_vld = 1'b0;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lock_d       = lock_q;
    rr_ptr_d     = rr_ptr_q;
    win_d        = win_q;
    score_d      = score_q;
    round_done_d = 1'b0;
    timeout_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // False starts are recorded even on the cycle start is taken.
        lock_d = lock_q | w_req;
        if (start) begin
          state_d = S_ARMED;
          cnt_d   = c_WIN_LOAD;
        end
      end

      S_ARMED: begin
        if (w_grant_vld) begin
          win_d    = w_grant_idx;
          rr_ptr_d = next_idx(w_grant_idx);
          cnt_d    = c_ANS_LOAD;
          state_d  = S_ANSWER;
        end else if (cnt_q == '0) begin
          state_d      = S_IDLE;
          lock_d       = '0;
          round_done_d = 1'b1;
          timeout_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - c_CNT_ONE;
        end
      end

      S_ANSWER: begin
        if (judge_ok) begin
          if (score_q[win_q] != c_SCORE_MAX) begin
            score_d[win_q] = score_q[win_q] + c_SCORE_ONE;
          end
          state_d      = S_IDLE;
          lock_d       = '0;
          round_done_d = 1'b1;
        end else if (judge_bad || (cnt_q == '0)) begin
          if (w_lock_fail == 3'b111) begin
            state_d      = S_IDLE;
            lock_d       = '0;
            round_done_d = 1'b1;
            timeout_d    = 1'b1;
          end else begin
            lock_d  = w_lock_fail;
            state_d = S_ARMED;
            cnt_d   = c_WIN_LOAD;
          end
        end else begin
          cnt_d = cnt_q - c_CNT_ONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Lamp and armed are registered images of the next state.
    lamp_d  = (state_d == S_ANSWER) ? (3'b001 << win_d) : 3'b000;
    armed_d = (state_d == S_ARMED);
  end

  always_ff @(posedge clk) begin
    if (X5) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      lock_q       <= '0;
      rr_ptr_q     <= '0;
      win_q        <= '0;
      score_q      <= '{default: '0};
      lamp_q       <= '0;
      armed_q      <= 1'b0;
      round_done_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lock_q       <= lock_d;
      rr_ptr_q     <= rr_ptr_d;
      win_q        <= win_d;
      score_q      <= score_d;
      lamp_q       <= lamp_d;
      armed_q      <= armed_d;
      round_done_q <= round_done_d;
      timeout_q    <= timeout_d;
    end
  end

  assign Y0         = lamp_q[0];
  assign Y1         = lamp_q[1];
  assign Y2         = lamp_q[2];
  assign armed      = armed_q;
  assign lock       = lock_q;
  assign score0     = score_q[0];
  assign score1     = score_q[1];
  assign score2     = score_q[2];
  assign round_done = round_done_q;
  assign timeout    = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_quiz_round_controller.sv
`default_nettype none
// ============================================================================
// tb_quiz_round_controller : directed plus randomized bench against a cycle model
// Revision 1.0 - initial release
// ============================================================================
module tb_quiz_round_controller;

  localparam int WINDOW  = 8;
  localparam int ANS_CYC = 4;
  localparam int SCORE_W = 4;
  localparam int c_SMAX  = (1 << SCORE_W) - 1;

  logic clk = 1'b0;
  logic X0, X1, X2, X3, X4, X5, start, judge_ok, judge_bad;
  logic Y0, Y1, Y2, armed, round_done, timeout;
  logic [2:0] lock;
  logic [SCORE_W-1:0] score0, score1, score2;

  int checks   = 0;
  int failures = 0;

  // Reference: phase 0 idle, 1 buzz window open, 2 someone answering.
  int         m_ph;
  int         m_left;
  int         m_win;
  int         m_rr;
  logic [2:0] m_lock;
  int         m_score [3];
  logic       m_done;
  logic       m_to;

  quiz_round_controller #(
    .WINDOW  (WINDOW),
    .ANS_CYC (ANS_CYC),
    .SCORE_W (SCORE_W)
  ) dut (
    .clk        (clk),
    .X5         (X5),
    .X0         (X0),
    .X1         (X1),
    .X2         (X2),
    .X3         (X3),
    .X4         (X4),
    .start      (start),
    .judge_ok   (judge_ok),
    .judge_bad  (judge_bad),
    .Y0         (Y0),
    .Y1         (Y1),
    .Y2         (Y2),
    .armed      (armed),
    .lock       (lock),
    .score0     (score0),
    .score1     (score1),
    .score2     (score2),
    .round_done (round_done),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic close_round(input logic was_timeout);
    m_ph   = 0;
    m_lock = 3'b000;
    m_done = 1'b1;
    m_to   = was_timeout;
  endtask

  task automatic model_step();
    logic [2:0] req;
    logic [2:0] elig;
    int         pick;
    req    = {X3 & X4, X2, X0 | X1};
    m_done = 1'b0;
    m_to   = 1'b0;
    if (X5) begin
      m_ph = 0; m_left = 0; m_win = 0; m_rr = 0; m_lock = 3'b000;
      for (int g = 0; g < 3; g++) m_score[g] = 0;
    end else if (m_ph == 0) begin
      m_lock = m_lock | req;
      if (start) begin
        m_ph   = 1;
        m_left = WINDOW;
      end
    end else if (m_ph == 1) begin
      elig = req & ~m_lock;
      pick = -1;
      for (int k = 0; k < 3; k++) begin
        if (pick < 0 && elig[(m_rr + k) % 3]) pick = (m_rr + k) % 3;
      end
      if (pick >= 0) begin
        m_win  = pick;
        m_rr   = (pick + 1) % 3;
        m_ph   = 2;
        m_left = ANS_CYC;
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) close_round(1'b1);
      end
    end else begin
      m_left = m_left - 1;
      if (judge_ok) begin
        if (m_score[m_win] < c_SMAX) m_score[m_win] = m_score[m_win] + 1;
        close_round(1'b0);
      end else if (judge_bad || m_left == 0) begin
        m_lock[m_win] = 1'b1;
        if (m_lock == 3'b111) begin
          close_round(1'b1);
        end else begin
          m_ph   = 1;
          m_left = WINDOW;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [2:0] exp_lamp;
    exp_lamp = (m_ph == 2) ? (3'b001 << m_win) : 3'b000;
    check("lamps",      32'({Y2, Y1, Y0}), 32'(exp_lamp));
    check("armed",      32'(armed),        32'(m_ph == 1));
    check("lock",       32'(lock),         32'(m_lock));
    check("score0",     32'(score0),       32'(m_score[0]));
    check("score1",     32'(score1),       32'(m_score[1]));
    check("score2",     32'(score2),       32'(m_score[2]));
    check("round_done", 32'(round_done),   32'(m_done));
    check("timeout",    32'(timeout),      32'(m_to));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic all_low();
    {X0, X1, X2, X3, X4, X5, start, judge_ok, judge_bad} = '0;
  endtask

  int n_armed;

  initial begin
    m_ph = 0; m_left = 0; m_win = 0; m_rr = 0; m_lock = 3'b000;
    m_done = 1'b0; m_to = 1'b0;
    for (int g = 0; g < 3; g++) m_score[g] = 0;
    all_low();
    X5 = 1'b1;
    tick();
    X5 = 1'b0;
    check("rst_lock", 32'(lock), 32'd0);
    check("rst_armed", 32'(armed), 32'd0);

    // Reset and first grant
    start = 1'b1; tick(); start = 1'b0;
    X0 = 1'b1; tick();
    check("s1_y0", 32'(Y0), 32'd1);
    tick(); X0 = 1'b0;
    judge_ok = 1'b1; tick(); judge_ok = 1'b0;
    check("s1_score0", 32'(score0), 32'd1);
    check("s1_done", 32'(round_done), 32'd1);

    // Tie resolved round-robin, twice
    start = 1'b1; tick(); start = 1'b0;
    X2 = 1'b1; X3 = 1'b1; X4 = 1'b1; tick();
    check("s2_y1", 32'(Y1), 32'd1);
    {X2, X3, X4} = '0; judge_ok = 1'b1; tick(); judge_ok = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    X2 = 1'b1; X3 = 1'b1; X4 = 1'b1; tick();
    check("s2_y2", 32'(Y2), 32'd1);
    {X2, X3, X4} = '0; judge_ok = 1'b1; tick(); judge_ok = 1'b0;

    // X3 alone never forms a professor request
    start = 1'b1; tick(); start = 1'b0; X3 = 1'b1;
    n_armed = 0;
    while (armed === 1'b1 && n_armed < 3 * WINDOW) begin
      n_armed++;
      tick();
    end
    check("s3_len", 32'(n_armed), 32'(WINDOW));
    check("s3_timeout", 32'(timeout), 32'd1);
    X3 = 1'b0;

    // Wrong answer, answer-timer expiry, exhaustion
    start = 1'b1; tick(); start = 1'b0;
    X0 = 1'b1; tick(); X0 = 1'b0;
    judge_bad = 1'b1; tick(); judge_bad = 1'b0;
    check("s4_lock1", 32'(lock), 32'b001);
    X2 = 1'b1; tick(); X2 = 1'b0;
    check("s4_y1", 32'(Y1), 32'd1);
    for (int i = 0; i < ANS_CYC; i++) tick();
    check("s4_lock2", 32'(lock), 32'b011);
    X3 = 1'b1; X4 = 1'b1; tick(); X3 = 1'b0; X4 = 1'b0;
    judge_bad = 1'b1; tick(); judge_bad = 1'b0;
    check("s4_timeout", 32'(timeout), 32'd1);
    check("s4_lock0", 32'(lock), 32'd0);

    // False start on the start cycle
    X2 = 1'b1; start = 1'b1; tick(); start = 1'b0;
    check("s5_lock", 32'(lock), 32'b010);
    for (int i = 0; i < 3; i++) tick();
    check("s5_nogrant", 32'(Y1), 32'd0);
    X0 = 1'b1; tick();
    check("s5_y0", 32'(Y0), 32'd1);
    X0 = 1'b0; X2 = 1'b0;
    judge_ok = 1'b1; tick(); judge_ok = 1'b0;

    // Score saturation then mid-round reset
    for (int i = 0; i < 16; i++) begin
      start = 1'b1; tick(); start = 1'b0;
      X3 = 1'b1; X4 = 1'b1; tick(); X3 = 1'b0; X4 = 1'b0;
      judge_ok = 1'b1; tick(); judge_ok = 1'b0;
    end
    check("s6_sat", 32'(score2), 32'(c_SMAX));
    start = 1'b1; tick(); start = 1'b0;
    X3 = 1'b1; X4 = 1'b1; tick(); X3 = 1'b0; X4 = 1'b0;
    X5 = 1'b1; tick(); X5 = 1'b0;
    check("s6_lamp", 32'({Y2, Y1, Y0}), 32'd0);
    check("s6_score2", 32'(score2), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      X0        = ($urandom_range(0, 5) == 0);
      X1        = ($urandom_range(0, 7) == 0);
      X2        = ($urandom_range(0, 5) == 0);
      X3        = ($urandom_range(0, 2) == 0);
      X4        = ($urandom_range(0, 2) == 0);
      start     = ($urandom_range(0, 3) == 0);
      judge_ok  = ($urandom_range(0, 5) == 0);
      judge_bad = ($urandom_range(0, 5) == 0);
      X5        = ($urandom_range(0, 299) == 0);
      tick();
    end
    all_low();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
